// File: rtl/mult_disp_pkg.sv
// Shared widths, FSM state encoding and segment constants for the result display path.
package mult_disp_pkg;
    localparam int BIN_W   = 8;
    localparam int DIG_W   = 4;
    localparam int NUM_DIG = 3;
    localparam int BCD_W   = NUM_DIG * DIG_W;
    localparam int CNT_W   = 3;
    localparam int SEG_W   = 7;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);
    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder, active-high, bit order gfedcba.
module bcd_to_seg7
    import mult_disp_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b0111111;
                4'd1:    seg = 7'b0000110;
                4'd2:    seg = 7'b1011011;
                4'd3:    seg = 7'b1001111;
                4'd4:    seg = 7'b1100110;
                4'd5:    seg = 7'b1101101;
                4'd6:    seg = 7'b1111101;
                4'd7:    seg = 7'b0000111;
                4'd8:    seg = 7'b1111111;
                4'd9:    seg = 7'b1101111;
                default: seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter from the 8-bit multiplier result to three BCD digits.
// Define SEVEN_SEG_EN to add blanked seven-segment outputs decoded from the held digits.
module result_bcd_converter
    import mult_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [DIG_W-1:0] bcd_hund,
    output logic [DIG_W-1:0] bcd_tens,
    output logic [DIG_W-1:0] bcd_ones,
    output logic             busy,
    output logic             done
`ifdef SEVEN_SEG_EN
    ,
    output logic [SEG_W-1:0] seg_hund,
    output logic [SEG_W-1:0] seg_tens,
    output logic [SEG_W-1:0] seg_ones
`endif
);
    // state | meaning
    // IDLE  | no result since reset, waiting for a start edge
    // SHIFT | double-dabble in progress, 8 shift cycles
    // DONE  | result held on bcd_*, waiting for the next start edge
    state_t state, state_next;

    logic             start_q;
    logic             start_edge;
    logic [BIN_W-1:0] bin_sr, bin_next;
    logic [BCD_W-1:0] bcd_sr, bcd_adj, bcd_next;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             last_shift;

    assign start_edge = start & ~start_q;
    assign capture    = start_edge && (state == IDLE || state == DONE);
    assign last_shift = (state == SHIFT) && (cnt == CNT_LAST);

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (bcd_sr[i*DIG_W +: DIG_W] >= 4'd5)
                bcd_adj[i*DIG_W +: DIG_W] = bcd_sr[i*DIG_W +: DIG_W] + 4'd3;
        end
        {bcd_next, bin_next} = {bcd_adj, bin_sr} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_next = DONE;
            DONE:    if (start_edge) state_next = SHIFT;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Outputs only move on the completing edge so the display never shows partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 1'b0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            bcd_hund <= '0;
            bcd_tens <= '0;
            bcd_ones <= '0;
        end else begin
            start_q <= start;
            if (capture) begin
                bin_sr <= bin_in;
                bcd_sr <= '0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                bin_sr <= bin_next;
                bcd_sr <= bcd_next;
                cnt    <= cnt + 1'b1;
                if (last_shift) begin
                    bcd_hund <= bcd_next[2*DIG_W +: DIG_W];
                    bcd_tens <= bcd_next[1*DIG_W +: DIG_W];
                    bcd_ones <= bcd_next[0*DIG_W +: DIG_W];
                end
            end
        end
    end

`ifdef SEVEN_SEG_EN
    logic blank_hund, blank_tens;

    assign blank_hund = (bcd_hund == '0);
    assign blank_tens = blank_hund && (bcd_tens == '0);

    bcd_to_seg7 u_seg_hund (.digit(bcd_hund), .blank(blank_hund), .seg(seg_hund));
    bcd_to_seg7 u_seg_tens (.digit(bcd_tens), .blank(blank_tens), .seg(seg_tens));
    bcd_to_seg7 u_seg_ones (.digit(bcd_ones), .blank(1'b0),       .seg(seg_ones));
`endif
endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter; build with SEVEN_SEG_EN to also check segments.
module tb_result_bcd_converter;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bin_in;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;
    logic       busy, done;
`ifdef SEVEN_SEG_EN
    logic [6:0] seg_hund, seg_tens, seg_ones;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .busy     (busy),
        .done     (done)
`ifdef SEVEN_SEG_EN
        ,
        .seg_hund (seg_hund),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
`endif
    );

    // Pulses start for one cycle then waits (bounded) for done; n = edges from capture to done.
    task automatic run_conversion(input logic [7:0] v, output int n);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 20 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b1;
        bin_in = 8'd123;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
        end
        n_cmp++;
        if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin
            n_bad++; $display("FAIL reset_digits: got %h expected 000", {bcd_hund, bcd_tens, bcd_ones});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_edge: busy=%b expected 1", busy);
        end
        start = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({done, bcd_hund, bcd_tens, bcd_ones} !== 13'h1123) begin
            n_bad++; $display("FAIL reset_release_result: done/digits=%b/%h expected 1/123",
                              done, {bcd_hund, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_max();
        start  = 1'b1;
        bin_in = 8'd225;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({busy, done} !== 2'b10 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h123) begin
                n_bad++; $display("FAIL max_during_shift[%0d]: busy/done=%b digits=%h expected 10 123",
                                  i, {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done} !== 2'b01 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h225) begin
            n_bad++; $display("FAIL max_result: busy/done=%b digits=%h expected 01 225",
                              {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_boundary();
        int n;
        run_conversion(8'd0, n);
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin
            n_bad++; $display("FAIL bound_0: latency=%0d digits=%h expected 8 000", n, {bcd_hund, bcd_tens, bcd_ones});
        end
        run_conversion(8'd255, n);
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h255) begin
            n_bad++; $display("FAIL bound_255: latency=%0d digits=%h expected 8 255", n, {bcd_hund, bcd_tens, bcd_ones});
        end
        run_conversion(8'd9, n);
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h009) begin
            n_bad++; $display("FAIL bound_9: latency=%0d digits=%h expected 8 009", n, {bcd_hund, bcd_tens, bcd_ones});
        end
`ifdef SEVEN_SEG_EN
        n_cmp++;
        if ({seg_hund, seg_tens, seg_ones} !== {7'b0, 7'b0, 7'b1101111}) begin
            n_bad++; $display("FAIL seg_9: got %b %b %b expected 0000000 0000000 1101111",
                              seg_hund, seg_tens, seg_ones);
        end
        run_conversion(8'd205, n);
        n_cmp++;
        if ({seg_hund, seg_tens, seg_ones} !== {7'b1011011, 7'b0111111, 7'b1101101}) begin
            n_bad++; $display("FAIL seg_205: got %b %b %b expected 1011011 0111111 1101101",
                              seg_hund, seg_tens, seg_ones);
        end
`endif
    endtask

    task automatic test_stuck_start();
        int n = 0;
        start  = 1'b1;
        bin_in = 8'd77;
        @(negedge clk);
        while (n < 20 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h077) begin
            n_bad++; $display("FAIL stuck_first: latency=%0d digits=%h expected 8 077", n, {bcd_hund, bcd_tens, bcd_ones});
        end
        bin_in = 8'd200;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b01 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h077) begin
                n_bad++; $display("FAIL stuck_hold[%0d]: busy/done=%b digits=%h expected 01 077",
                                  i, {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_during_shift();
        int n = 0;
        start  = 1'b1;
        bin_in = 8'd50;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n = 2;
        start  = 1'b1;
        bin_in = 8'd99;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (n < 20 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h050) begin
            n_bad++; $display("FAIL mid_start_result: latency=%0d digits=%h expected 8 050", n, {bcd_hund, bcd_tens, bcd_ones});
        end
        for (int i = 0; i < 12; i++) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b01 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h050) begin
            n_bad++; $display("FAIL mid_start_no_queue: busy/done=%b digits=%h expected 01 050",
                              {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        run_conversion(8'd6, n);
        n_cmp++;
        if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h006) begin
            n_bad++; $display("FAIL rmid_prior: digits=%h expected 006", {bcd_hund, bcd_tens, bcd_ones});
        end
        start  = 1'b1;
        bin_in = 8'd144;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_cmp++;
        if ({busy, bcd_hund, bcd_tens, bcd_ones} !== 13'h1006) begin
            n_bad++; $display("FAIL rmid_before_rst: busy/digits=%b/%h expected 1/006", busy, {bcd_hund, bcd_tens, bcd_ones});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin
            n_bad++; $display("FAIL rmid_abort: busy/done=%b digits=%h expected 00 000",
                              {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
        end
        run_conversion(8'd81, n);
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h081) begin
            n_bad++; $display("FAIL rmid_after: latency=%0d digits=%h expected 8 081", n, {bcd_hund, bcd_tens, bcd_ones});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_conversion(8'd4, n);
        n_cmp++;
        if (n !== 8 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h004) begin
            n_bad++; $display("FAIL b2b_first: latency=%0d digits=%h expected 8 004", n, {bcd_hund, bcd_tens, bcd_ones});
        end
        start  = 1'b1;
        bin_in = 8'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({busy, done} !== 2'b10 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h004) begin
                n_bad++; $display("FAIL b2b_hold[%0d]: busy/done=%b digits=%h expected 10 004",
                                  i, {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done} !== 2'b01 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h009) begin
            n_bad++; $display("FAIL b2b_second: busy/done=%b digits=%h expected 01 009",
                              {busy, done}, {bcd_hund, bcd_tens, bcd_ones});
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        @(negedge clk);
        test_reset();
        test_max();
        test_boundary();
        test_stuck_start();
        test_start_during_shift();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 No parameters SHALL exist; widths SHALL come from package constants BIN_W=8 and DIG_W=4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level; driven by the multiplier done, and a rising edge SHALL request a conversion.
REQ-005 bin_in  input  8  unsigned binary value, the multiplier result.
REQ-006 bcd_hund / bcd_tens / bcd_ones  output  4 each  registered BCD digits of the last completed conversion.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  high while a completed result is held.

Function
REQ-009 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-010 Registering start_q each cycle, the block SHALL treat start=1 with start_q=0 as a start edge.
REQ-011 A start edge seen in IDLE or DONE SHALL capture bin_in, clear the shift counter, drop done and enter SHIFT on that same clock edge.
REQ-012 In SHIFT, each cycle SHALL add 3 to every BCD digit >= 5 and then shift {bcd,bin} left by one bit (double-dabble).
REQ-013 After exactly 8 SHIFT cycles, the block SHALL load the bcd_* outputs, set done=1, set busy=0 and enter DONE.
REQ-014 done SHALL rise on the 8th clock edge after the capturing edge, and busy SHALL be high during the cycles in between.
REQ-015 done SHALL stay high in DONE until the next start edge; start held high SHALL NOT retrigger a conversion.
REQ-016 A start edge during SHIFT SHALL be ignored and SHALL NOT be queued.
REQ-017 The bcd_* outputs SHALL hold their previous values during SHIFT and change only on the completing edge.
REQ-018 Range: 0..255 SHALL map to hundreds 0..2, tens 0..9 and ones 0..9, and no digit SHALL ever exceed 9.

Reset
REQ-019 When rst=1, on the next clock edge the block SHALL set the state to IDLE and clear busy, done, all bcd_* outputs, the shift register, the counter and start_q.
REQ-020 Reset SHALL take priority over any start edge in the same cycle.
REQ-021 Reset during SHIFT SHALL abort the conversion with no result update.
REQ-022 If start is high in the first cycle after reset release, that SHALL count as a start edge.

Configuration
REQ-023 With SEVEN_SEG_EN defined, the block SHALL add outputs seg_hund, seg_tens and seg_ones (each 7 bits, active-high, bit order gfedcba), decoded from the registered digits.
REQ-024 With SEVEN_SEG_EN defined, leading-zero blanking SHALL apply:
  - seg_hund SHALL be all zeros when bcd_hund=0;
  - seg_tens SHALL be all zeros when both bcd_hund and bcd_tens are 0;
  - seg_ones SHALL always show its digit.
REQ-025 With SEVEN_SEG_EN undefined, the seg_* ports and the decode logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package mult_disp_pkg SHALL hold:
  - constants BIN_W and DIG_W;
  - the FSM state enum;
  - the segment blank constant.
REQ-027 The seven-segment decode SHALL be sub-module bcd_to_seg7: combinational, 4-bit input, 7-bit output, with a blank input; it SHALL be instantiated 3 times under SEVEN_SEG_EN only.

Verification
REQ-028 Scenario, max value: bin_in=225 with a start pulse -> done high 8 edges after capture, busy high in between, digits 2/2/5.
REQ-029 Scenario, boundary values:
  - bin_in=0 -> digits 0/0/0;
  - bin_in=255 -> digits 2/5/5;
  - bin_in=9 -> digits 0/0/9, and with SEVEN_SEG_EN, seg_hund=seg_tens=0 and seg_ones=7'b1101111.
REQ-030 Scenario, stuck start: start held high from the edge through 50 extra cycles -> exactly one conversion, done remains 1 and the digits are stable.
REQ-031 Scenario, start during SHIFT: convert 50, then pulse start again at cycle 3 with bin_in=99 -> result 0/5/0 and no second conversion.
REQ-032 Scenario, reset mid-flight: a prior result of 6 is held, start 144, assert rst at cycle 4 -> next cycle done=0, busy=0, digits 0/0/0; then start 81 -> digits 0/8/1.
REQ-033 Scenario, back-to-back: start 4, await done, then immediately start 9 -> the first result is 0/0/4 and holds until the second completes with 0/0/9.
